// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and constants for the LEGv8 register file.
//   REG_ADDR_W : register index width
//   XZR        : index of the hardwired-zero register
//   reg_addr_t : register index type
//   xword_t    : 64-bit architectural data word
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] XZR = 5'd31;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [63:0]           xword_t;

endpackage

// File: rtl/regfile_decoder5_32.sv
// decoder5_32: one-hot write-enable decoder.
//   en     : global enable (write request already qualified by reset)
//   addr   : register index
//   onehot : one bit per register, at most one set, all zero when en is low
module decoder5_32 #(
    parameter int ADDR_W = 5,
    parameter int NOUT   = 32
) (
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    output logic [NOUT-1:0]   onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_mux2_1.sv
// mux2_1: WIDTH-bit two-input multiplexer.
//   d0, d1 : data inputs
//   sel    : 0 selects d0, 1 selects d1
//   y      : selected data
module mux2_1 #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/regfile.sv
// regfile: 32 x 64-bit LEGv8 register file, two combinational read ports,
// one synchronous write port, write-through bypass, X31 (XZR) reads zero.
//   clk       : clock, all state changes on posedge
//   reset     : synchronous active-high, clears every register
//   rd_addr1  : read port 1 index      rd_data1 : read port 1 data
//   rd_addr2  : read port 2 index      rd_data2 : read port 2 data
//   reg_write : write enable
//   wr_addr   : write index            wr_data  : write data
module regfile
    import regfile_pkg::*;
#(
    parameter int WIDTH    = $bits(xword_t),
    parameter int NREGS    = 32,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int ZERO_REG = int'(XZR)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [WIDTH-1:0]  rd_data1,
    output logic [WIDTH-1:0]  rd_data2,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
    localparam int                NODES     = 2 * NREGS - 1;
    localparam logic [NREGS-1:0]  XZR_MASK  = ~(NREGS'(1) << ZERO_REG);

    logic [NREGS-1:0]  wr_onehot;
    logic [NREGS-1:0]  wr_en;
    logic [WIDTH-1:0]  regs     [NREGS];
    logic [ADDR_W-1:0] rd_addr  [2];
    logic [WIDTH-1:0]  tree     [2][NODES];
    logic [WIDTH-1:0]  byp_out  [2];
    logic [WIDTH-1:0]  rd_data  [2];
    logic              bypass   [2];

    assign rd_addr[0] = rd_addr1;
    assign rd_addr[1] = rd_addr2;
    assign rd_data1   = rd_data[0];
    assign rd_data2   = rd_data[1];

    decoder5_32 #(
        .ADDR_W (ADDR_W),
        .NOUT   (NREGS)
    ) u_dec (
        .en     (reg_write & ~reset),
        .addr   (wr_addr),
        .onehot (wr_onehot)
    );

    // XZR has no enable, so its flop only ever holds the reset value.
    assign wr_en = wr_onehot & XZR_MASK;

    always_ff @(posedge clk) begin
        for (int r = 0; r < NREGS; r++) begin
            if (reset) begin
                regs[r] <= '0;
            end else if (wr_en[r]) begin
                regs[r] <= wr_data;
            end
        end
    end

    // Read select is a binary heap of mux2_1: node k has children 2k+1/2k+2,
    // leaves NREGS-1+i hold regs[i], and depth d is steered by address bit
    // ADDR_W-1-d so the root picks the upper or lower half.
    for (genvar p = 0; p < 2; p++) begin : g_port
        for (genvar i = 0; i < NREGS; i++) begin : g_leaf
            assign tree[p][NREGS-1+i] = regs[i];
        end

        for (genvar d = 0; d < ADDR_W; d++) begin : g_lvl
            for (genvar j = 0; j < (1 << d); j++) begin : g_mux
                localparam int K = (1 << d) - 1 + j;
                mux2_1 #(.WIDTH(WIDTH)) u_mux (
                    .d0  (tree[p][2*K+1]),
                    .d1  (tree[p][2*K+2]),
                    .sel (rd_addr[p][ADDR_W-1-d]),
                    .y   (tree[p][K])
                );
            end
        end

        // Bypass is suppressed during reset so reads show stored contents.
        assign bypass[p] = ~reset & reg_write & (wr_addr == rd_addr[p])
                         & (wr_addr != ZERO_ADDR);

        mux2_1 #(.WIDTH(WIDTH)) u_byp (
            .d0  (tree[p][0]),
            .d1  (wr_data),
            .sel (bypass[p]),
            .y   (byp_out[p])
        );

        assign rd_data[p] = byp_out[p] & {WIDTH{rd_addr[p] != ZERO_ADDR}};
    end

endmodule

// File: tb/tb_regfile.sv
module tb_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rd_addr1, rd_addr2, wr_addr;
    logic [63:0] rd_data1, rd_data2, wr_data;
    logic        reg_write;

    regfile dut (
        .clk       (clk),
        .reset     (reset),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .rd_data1  (rd_data1),
        .rd_data2  (rd_data2),
        .reg_write (reg_write),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] e1;
        logic [63:0] e2;
        logic [4:0]  a1;
        logic [4:0]  a2;
    } exp_t;

    exp_t        sb_q[$];
    logic [63:0] model [32];
    bit          chk_valid = 1'b0;
    int          checks    = 0;
    int          failures  = 0;

    // Reference: XZR is zero, a same-cycle write wins when not in reset,
    // otherwise the architectural value.
    function automatic logic [63:0] ref_read(input logic [4:0] a, input bit r,
                                             input bit we, input logic [4:0] wa,
                                             input logic [63:0] wd);
        if (a == 5'd31)                return 64'd0;
        if (!r && we && wa == a)       return wd;
        return model[a];
    endfunction

    task automatic step(input bit r, input bit we, input logic [4:0] wa,
                        input logic [63:0] wd, input logic [4:0] a1,
                        input logic [4:0] a2, input bit chk);
        exp_t e;
        reset     = r;
        reg_write = we;
        wr_addr   = wa;
        wr_data   = wd;
        rd_addr1  = a1;
        rd_addr2  = a2;
        if (chk) begin
            e.e1 = ref_read(a1, r, we, wa, wd);
            e.e2 = ref_read(a2, r, we, wa, wd);
            e.a1 = a1;
            e.a2 = a2;
            sb_q.push_back(e);
        end
        chk_valid = chk;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) model[i] = 64'd0;
        end else if (we && wa != 5'd31) begin
            model[wa] = wd;
        end
        #1;
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
        step(1'b0, 1'b0, 5'd0, 64'd0, a1, a2, 1'b1);
    endtask

    // Monitor: read data is valid mid-cycle; compare against the oldest entry.
    always @(negedge clk) begin
        if (chk_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty at %0t", $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checks++;
                if (rd_data1 !== e.e1) begin
                    failures++;
                    $display("FAIL rd1 addr=%0d got=%h exp=%h at %0t", e.a1, rd_data1, e.e1, $time);
                end
                checks++;
                if (rd_data2 !== e.e2) begin
                    failures++;
                    $display("FAIL rd2 addr=%0d got=%h exp=%h at %0t", e.a2, rd_data2, e.e2, $time);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  a1, a2, wa;
        bit          r, we;
        reset     = 1'b1;
        reg_write = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_addr1  = '0;
        rd_addr2  = '0;
        @(posedge clk);
        #1;

        // Reset for one cycle, then every register reads zero.
        step(1'b1, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0, 1'b0);
        for (int i = 0; i < 32; i++) rd(5'(i), 5'(31 - i));

        // X5 write with same-cycle bypass, then a plain read.
        step(1'b0, 1'b1, 5'd5, 64'h0123_4567_89AB_CDEF, 5'd5, 5'd6, 1'b1);
        rd(5'd5, 5'd6);

        // Write to XZR is dropped, no bypass either.
        step(1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31, 1'b1);
        rd(5'd31, 5'd31);

        // Both ports bypass the same register.
        step(1'b0, 1'b1, 5'd7, 64'd100, 5'd7, 5'd7, 1'b1);
        rd(5'd7, 5'd5);

        // Back-to-back writes to one register: last wins.
        step(1'b0, 1'b1, 5'd12, 64'd1, 5'd12, 5'd0, 1'b1);
        step(1'b0, 1'b1, 5'd12, 64'd2, 5'd12, 5'd0, 1'b1);
        rd(5'd12, 5'd12);

        // Reset beats a pending write; bypass off while reset is high.
        step(1'b0, 1'b1, 5'd9, 64'd50, 5'd0, 5'd1, 1'b1);
        step(1'b1, 1'b1, 5'd9, 64'd77, 5'd9, 5'd9, 1'b1);
        rd(5'd9, 5'd7);

        // Fill X0..X30 with i*3 and read back random pairs.
        for (int i = 0; i < 31; i++)
            step(1'b0, 1'b1, 5'(i), 64'(i * 3), 5'($urandom_range(0, 31)), 5'(i), 1'b1);
        for (int i = 0; i < 40; i++)
            rd(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));

        // Random mixed traffic with occasional reset.
        for (int i = 0; i < 300; i++) begin
            r  = ($urandom_range(0, 39) == 0);
            we = ($urandom_range(0, 3) != 0);
            wa = 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            step(r, we, wa, {$urandom, $urandom}, a1, a2, 1'b1);
        end

        chk_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
